// File: rtl/fpu_operand_prep.sv
// rtl/fpu_operand_prep.sv - two-stage operand unbox/widen, sign manipulation and classify pipeline
// S1 holds raw inputs, S2 holds widened and classified operands; both advance under valid/ready.
module fpu_operand_prep #(
  parameter int NUM_SRC    = 2,
  parameter bit NANBOX_CHK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*NUM_SRC-1:0] in_ops,
  input  logic [2:0]            in_op_type,
  input  logic                  in_fmt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*NUM_SRC-1:0] out_ops,
  output logic [2:0]            out_op_type,
  output logic [5*NUM_SRC-1:0]  out_class
);

  localparam int W  = 64 * NUM_SRC;
  localparam int CW = 5 * NUM_SRC;

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_ops_q, s1_ops_d;
  logic [2:0]    s1_type_q, s1_type_d;
  logic          s1_fmt_q, s1_fmt_d;
  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_ops_q, s2_ops_d;
  logic [CW-1:0] s2_class_q, s2_class_d;
  logic [2:0]    s2_type_q, s2_type_d;

  logic          adv1, adv2;
  logic          conv_sp;
  logic [63:0]   op_w;
  logic [W-1:0]  prep_ops;
  logic [CW-1:0] prep_class;

  function automatic logic [63:0] widen(input logic [63:0] op, input logic to_dp);
    logic [7:0]  e;
    logic [10:0] de;
    e = op[30:23];
    if (e == 8'd0)
      de = 11'd0;
    else if (e == 8'hFF)
      de = 11'h7FF;
    else
      de = {3'b000, e} + 11'd896;
    if (!to_dp)
      widen = op;
    else if (NANBOX_CHK && (op[63:32] != 32'hFFFF_FFFF))
      widen = 64'h7FF8_0000_0000_0000;
    else
      widen = {op[31], de, op[22:0], 29'd0};
  endfunction

  // {snan, qnan, inf, subnormal, zero}; sign is deliberately ignored
  function automatic logic [4:0] classify(input logic [63:0] d);
    logic exp_zero, exp_ones, frac_zero;
    exp_zero  = (d[62:52] == 11'd0);
    exp_ones  = (d[62:52] == 11'h7FF);
    frac_zero = (d[51:0] == 52'd0);
    classify  = {exp_ones & ~frac_zero & ~d[51],
                 exp_ones & d[51],
                 exp_ones & frac_zero,
                 exp_zero & ~frac_zero,
                 exp_zero & frac_zero};
  endfunction

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  always_comb begin
    conv_sp    = (s1_type_q[2] & s1_type_q[1]) ^ s1_fmt_q;
    op_w       = '0;
    prep_ops   = '0;
    prep_class = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      op_w = widen(s1_ops_q[64*k +: 64], conv_sp);
      if (k == 0 && s1_type_q == 3'b101) op_w[63] = ~op_w[63];
      if (k == 0 && s1_type_q == 3'b100) op_w[63] = 1'b0;
      if (k == 1 && s1_type_q == 3'b001) op_w[63] = ~op_w[63];
      prep_ops[64*k +: 64]  = op_w;
      prep_class[5*k +: 5]  = classify(op_w);
    end
  end

  // Data registers only load on a real transfer so outputs hold during stalls
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ops_d   = s1_ops_q;
    s1_type_d  = s1_type_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_ops_d   = s2_ops_q;
    s2_class_d = s2_class_q;
    s2_type_d  = s2_type_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_ops_d  = in_ops;
        s1_type_d = in_op_type;
        s1_fmt_d  = in_fmt;
      end
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ops_d   = prep_ops;
        s2_class_d = prep_class;
        s2_type_d  = s1_type_q;
      end
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ops_q   <= '0;
      s1_type_q  <= '0;
      s1_fmt_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_ops_q   <= '0;
      s2_class_q <= '0;
      s2_type_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ops_q   <= s1_ops_d;
      s1_type_q  <= s1_type_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_ops_q   <= s2_ops_d;
      s2_class_q <= s2_class_d;
      s2_type_q  <= s2_type_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_ops     = s2_ops_q;
  assign out_class   = s2_class_q;
  assign out_op_type = s2_type_q;

endmodule
